// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared types and constants for the layer sequencer.
//   seq_state_t : sequencer FSM state (capture / replay)
//   STAT_W      : width of the optional statistics counters
//   idx_width() : stream index width, kept at least 1 bit so NN = 1 still elaborates
package layer_seq_pkg;

    typedef enum logic [0:0] {
        Idle   = 1'b0,
        Stream = 1'b1
    } seq_state_t;

    localparam int unsigned STAT_W = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_seq_ctrl_if.sv
// layer_seq_ctrl_if: groups the result-capture inputs and the replay stream outputs.
//   o_valid_in [NN]            per-neuron result strobes
//   x_vec_in   [NN*dataWidth]  neuron results, neuron i at [i*dataWidth +: dataWidth]
//   out_ready                  downstream accept
//   x_valid, x_out             replay stream
//   busy, layer_done, overrun  status
//   frame_count, drop_count    statistics (only with LAYER_SEQ_STATS_EN defined)
// Modports: slave = sequencer side, master = producer/consumer side.
interface layer_seq_ctrl_if #(
    parameter int unsigned NN        = 30,
    parameter int unsigned dataWidth = 16
);
    import layer_seq_pkg::*;

    logic [NN-1:0]           o_valid_in;
    logic [NN*dataWidth-1:0] x_vec_in;
    logic                    out_ready;
    logic                    x_valid;
    logic [dataWidth-1:0]    x_out;
    logic                    busy;
    logic                    layer_done;
    logic                    overrun;
`ifdef LAYER_SEQ_STATS_EN
    logic [STAT_W-1:0]       frame_count;
    logic [STAT_W-1:0]       drop_count;
`endif

    modport slave (
        input  o_valid_in, x_vec_in, out_ready,
`ifdef LAYER_SEQ_STATS_EN
        output frame_count, drop_count,
`endif
        output x_valid, x_out, busy, layer_done, overrun
    );

    modport master (
        output o_valid_in, x_vec_in, out_ready,
`ifdef LAYER_SEQ_STATS_EN
        input  frame_count, drop_count,
`endif
        input  x_valid, x_out, busy, layer_done, overrun
    );

endinterface

// File: rtl/layer_seq_buf.sv
// layer_seq_buf: NN-entry result buffer with per-entry captured flags.
//   clk, rst     : clock, synchronous active-high reset (buffer and flags to 0)
//   we [NN]      : per-entry write enable, also sets that entry's flag
//   din          : packed entry data, entry i at [i*dataWidth +: dataWidth]
//   clr          : synchronous flag clear (data is kept)
//   idx          : read index
//   rd_data      : buf[idx]
//   all_captured : every flag set once this cycle's writes are included
module layer_seq_buf #(
    parameter int unsigned NN        = 30,
    parameter int unsigned dataWidth = 16,
    parameter int unsigned IdxW      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           we,
    input  logic [NN*dataWidth-1:0] din,
    input  logic                    clr,
    input  logic [IdxW-1:0]         idx,
    output logic [dataWidth-1:0]    rd_data,
    output logic                    all_captured
);

    logic [dataWidth-1:0] mem_q [NN];
    logic [NN-1:0]        flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) mem_q[i] <= '0;
            flag_q <= '0;
        end else begin
            for (int i = 0; i < NN; i++) begin
                if (we[i]) mem_q[i] <= din[i*dataWidth +: dataWidth];
            end
            flag_q <= clr ? '0 : (flag_q | we);
        end
    end

    // Look ahead through this cycle's strobes so the last one starts the replay at once.
    assign all_captured = &(flag_q | we);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NN; i++) begin
            if (idx == IdxW'(i)) rd_data = mem_q[i];
        end
    end

endmodule

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: collects NN neuron results, then replays them as a serial stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : layer_seq_ctrl_if slave (strobes/data in, x_valid/x_out stream out, status)
// Optional: define LAYER_SEQ_STATS_EN to add saturating frame_count / drop_count.
module layer_seq_ctrl
    import layer_seq_pkg::*;
#(
    parameter int unsigned NN        = 30,
    parameter int unsigned dataWidth = 16
) (
    input  logic           clk,
    input  logic           rst,
    layer_seq_ctrl_if.slave bus
);

    localparam int unsigned   IdxW    = idx_width(NN);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NN - 1);

    seq_state_t           state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 done_q, done_d;
    logic                 overrun_q;
    logic [NN-1:0]        we;
    logic                 clr;
    logic                 drop;
    logic                 all_captured;
    logic [dataWidth-1:0] rd_data;

    layer_seq_buf #(
        .NN        (NN),
        .dataWidth (dataWidth),
        .IdxW      (IdxW)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .din          (bus.x_vec_in),
        .clr          (clr),
        .idx          (idx_q),
        .rd_data      (rd_data),
        .all_captured (all_captured)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        we      = '0;
        clr     = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            Idle: begin
                we = bus.o_valid_in;
                if (all_captured) begin
                    clr     = 1'b1;
                    idx_d   = '0;
                    state_d = Stream;
                end
            end
            Stream: begin
                // Strobes during replay are discarded, including on the final transfer.
                drop = |bus.o_valid_in;
                if (bus.out_ready) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = Idle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= Idle;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (drop) overrun_q <= 1'b1;
        end
    end

    assign bus.x_valid    = (state_q == Stream);
    assign bus.busy       = (state_q == Stream);
    assign bus.x_out      = (state_q == Stream) ? rd_data : '0;
    assign bus.layer_done = done_q;
    assign bus.overrun    = overrun_q;

`ifdef LAYER_SEQ_STATS_EN
    logic [STAT_W-1:0] frame_q;
    logic [STAT_W-1:0] drops_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            drops_q <= '0;
        end else begin
            if (done_q && (frame_q != '1)) frame_q <= frame_q + 1'b1;
            if (drop && (drops_q != '1)) drops_q <= drops_q + 1'b1;
        end
    end

    assign bus.frame_count = frame_q;
    assign bus.drop_count  = drops_q;
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: directed bench for layer_seq_ctrl with NN = 4, dataWidth = 16.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point,
// i.e. they reflect the cycle that follows that edge.
module tb_layer_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    layer_seq_ctrl_if #(.NN(4), .dataWidth(16)) bus ();

    layer_seq_ctrl #(
        .NN        (4),
        .dataWidth (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] mask, input logic [63:0] vec);
        bus.o_valid_in = mask;
        bus.x_vec_in   = vec;
        tick();
        bus.o_valid_in = '0;
    endtask

    // Called in the first stream cycle, out_ready held at 1; vals packs element k at [k*16 +: 16].
    task automatic expect_stream(input string tag, input logic [63:0] vals);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("%s_valid%0d", tag, k), 32'(bus.x_valid), 32'd1);
            check_eq($sformatf("%s_x%0d", tag, k), 32'(bus.x_out), 32'(vals[k*16 +: 16]));
            check_eq($sformatf("%s_nodone%0d", tag, k), 32'(bus.layer_done), 32'd0);
            tick();
        end
        check_eq({tag, "_done"}, 32'(bus.layer_done), 32'd1);
        check_eq({tag, "_done_novalid"}, 32'(bus.x_valid), 32'd0);
        check_eq({tag, "_done_idle"}, 32'(bus.busy), 32'd0);
        tick();
        check_eq({tag, "_done_pulse"}, 32'(bus.layer_done), 32'd0);
    endtask

    initial begin
        logic [6:0]  rdy_pat;
        logic [63:0] bp_vals;
        int          k;

        rst            = 1'b1;
        bus.o_valid_in = '0;
        bus.x_vec_in   = '0;
        bus.out_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_valid", 32'(bus.x_valid), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.layer_done), 32'd0);
        check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
        check_eq("rst_xout", 32'(bus.x_out), 32'd0);
`ifdef LAYER_SEQ_STATS_EN
        check_eq("rst_frames", 32'(bus.frame_count), 32'd0);
        check_eq("rst_drops", 32'(bus.drop_count), 32'd0);
`endif

        // Simultaneous capture.
        strobe(4'b1111, {16'h0044, 16'h0033, 16'h0022, 16'h0011});
        expect_stream("simul", {16'h0044, 16'h0033, 16'h0022, 16'h0011});

        // Skewed strobes 2, 0, 0(again), 3, 1.
        strobe(4'b0100, {16'h0000, 16'h00C2, 16'h0000, 16'h0000});
        check_eq("skew_wait2", 32'(bus.busy), 32'd0);
        strobe(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h00AA});
        check_eq("skew_wait0", 32'(bus.busy), 32'd0);
        strobe(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h00BB});
        check_eq("skew_wait0b", 32'(bus.busy), 32'd0);
        strobe(4'b1000, {16'h00D3, 16'h0000, 16'h0000, 16'h0000});
        check_eq("skew_wait3", 32'(bus.busy), 32'd0);
        strobe(4'b0010, {16'h0000, 16'h0000, 16'h00E1, 16'h0000});
        expect_stream("skew", {16'h00D3, 16'h00C2, 16'h00E1, 16'h00BB});

        // Back-pressure 1,0,0,1,1,0,1 (applied in that order, cycle by cycle).
        rdy_pat = 7'b1011001;
        bp_vals = {16'h0104, 16'h0103, 16'h0102, 16'h0101};
        k = 0;
        strobe(4'b1111, bp_vals);
        for (int c = 0; c < 7; c++) begin
            check_eq($sformatf("bp_valid%0d", c), 32'(bus.x_valid), 32'd1);
            check_eq($sformatf("bp_x%0d", c), 32'(bus.x_out), 32'(bp_vals[k*16 +: 16]));
            check_eq($sformatf("bp_nodone%0d", c), 32'(bus.layer_done), 32'd0);
            bus.out_ready = rdy_pat[c];
            tick();
            if (rdy_pat[c]) k++;
        end
        bus.out_ready = 1'b1;
        check_eq("bp_done", 32'(bus.layer_done), 32'd1);
        check_eq("bp_done_novalid", 32'(bus.x_valid), 32'd0);
        tick();

        // Overrun: neuron 1 strobes while element 2 is presented.
        strobe(4'b1111, {16'h0204, 16'h0203, 16'h0202, 16'h0201});
        check_eq("ovr_x0", 32'(bus.x_out), 32'h0201);
        tick();
        check_eq("ovr_x1", 32'(bus.x_out), 32'h0202);
        check_eq("ovr_clear", 32'(bus.overrun), 32'd0);
        tick();
        check_eq("ovr_x2", 32'(bus.x_out), 32'h0203);
        strobe(4'b0010, {16'h0000, 16'h0000, 16'hDEAD, 16'h0000});
        check_eq("ovr_set", 32'(bus.overrun), 32'd1);
        check_eq("ovr_x3", 32'(bus.x_out), 32'h0204);
        tick();
        check_eq("ovr_done", 32'(bus.layer_done), 32'd1);
        tick();
        strobe(4'b1101, {16'h0304, 16'h0303, 16'h0000, 16'h0301});
        check_eq("ovr_needs_all", 32'(bus.busy), 32'd0);
        strobe(4'b0010, {16'h0000, 16'h0000, 16'h0302, 16'h0000});
        expect_stream("ovr_next", {16'h0304, 16'h0303, 16'h0302, 16'h0301});
        check_eq("ovr_sticky", 32'(bus.overrun), 32'd1);
`ifdef LAYER_SEQ_STATS_EN
        check_eq("stat_drops", 32'(bus.drop_count), 32'd1);
        check_eq("stat_frames", 32'(bus.frame_count), 32'd5);
`endif

        // Reset during element 1.
        strobe(4'b1111, {16'h0404, 16'h0403, 16'h0402, 16'h0401});
        check_eq("rms_x0", 32'(bus.x_out), 32'h0401);
        tick();
        check_eq("rms_x1", 32'(bus.x_out), 32'h0402);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rms_valid", 32'(bus.x_valid), 32'd0);
        check_eq("rms_busy", 32'(bus.busy), 32'd0);
        check_eq("rms_done", 32'(bus.layer_done), 32'd0);
        check_eq("rms_overrun", 32'(bus.overrun), 32'd0);
        check_eq("rms_xout", 32'(bus.x_out), 32'd0);
        tick();
        check_eq("rms_nodone", 32'(bus.layer_done), 32'd0);
        strobe(4'b0111, {16'h0000, 16'h0503, 16'h0502, 16'h0501});
        check_eq("rms_partial", 32'(bus.busy), 32'd0);
        strobe(4'b1000, {16'h0504, 16'h0000, 16'h0000, 16'h0000});
        expect_stream("rms_new", {16'h0504, 16'h0503, 16'h0502, 16'h0501});
`ifdef LAYER_SEQ_STATS_EN
        check_eq("stat_frames_rst", 32'(bus.frame_count), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
